// File: rtl/hex2decdigi_seq.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock) with
// 7-segment encoding, optional leading-zero blanking and overflow dashes.
module hex2decdigi_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  hex_valid,
  input  logic [WIDTH-1:0]      hex,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   digi
);

  localparam int ND = (WIDTH + 2) / 3 + 1;
  localparam int BW = 4 * ND;
  localparam int ED = (ND > DIGITS) ? ND : DIGITS;
  localparam int EW = 4 * ED;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t             state, state_nxt;
  logic               load_hex, load_pend;
  logic               pend_full;
  logic [WIDTH-1:0]   pend_hex;
  logic [WIDTH-1:0]   shift_q;
  logic [BW-1:0]      work_q;
  logic [BW-1:0]      work_adj;
  logic [CW-1:0]      cnt;
  logic [EW-1:0]      ext;
  logic               ovf_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic has_ovf(input logic [EW-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = DIGITS; i < ED; i++)
      if (v[4*i +: 4] != 4'd0) r = 1'b1;
    return r;
  endfunction

  // Scans from the most significant displayed digit so blanking stops at the
  // first nonzero digit; overflow overrides everything with dashes.
  function automatic logic [7*DIGITS-1:0] encode(input logic [EW-1:0] v, input logic ovf);
    logic [7*DIGITS-1:0] r;
    logic                lead;
    logic [3:0]          d;
    r    = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (ovf) begin
        r[7*i +: 7] = 7'h40;
      end else if (BLANK_LZ != 0 && lead && i > 0 && d == 4'd0) begin
        r[7*i +: 7] = 7'h00;
      end else begin
        r[7*i +: 7] = seg7(d);
        lead        = 1'b0;
      end
    end
    return r;
  endfunction

  assign work_adj = add3(work_q);
  assign ext      = EW'(work_q);
  assign ovf_c    = has_ovf(ext);
  assign busy     = (state != IDLE) || pend_full;

  always_comb begin
    state_nxt = state;
    load_hex  = 1'b0;
    load_pend = 1'b0;
    case (state)
      IDLE: begin
        if (hex_valid) begin
          load_hex  = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (cnt == CW'(1)) state_nxt = OUT;
      end
      OUT: begin
        if (hex_valid) begin
          load_hex  = 1'b1;
          state_nxt = CONV;
        end else if (pend_full) begin
          load_pend = 1'b1;
          state_nxt = CONV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      pend_full <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd       <= '0;
      digi      <= encode('0, 1'b0);
    end else begin
      state <= state_nxt;
      done  <= (state == OUT);
      if (state == CONV && hex_valid)
        pend_full <= 1'b1;
      else if (load_pend)
        pend_full <= 1'b0;
      if (state == OUT) begin
        overflow <= ovf_c;
        bcd      <= ext[4*DIGITS-1:0];
        digi     <= encode(ext, ovf_c);
      end
    end
  end

  // Conversion datapath; contents are don't-care until loaded
  always_ff @(posedge clock) begin
    if (state == CONV && hex_valid) pend_hex <= hex;
    if (load_hex || load_pend) begin
      shift_q <= load_hex ? hex : pend_hex;
      work_q  <= '0;
      cnt     <= CW'(WIDTH);
    end else if (state == CONV) begin
      work_q  <= {work_adj[BW-2:0], shift_q[WIDTH-1]};
      shift_q <= shift_q << 1;
      cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hex2decdigi_seq.sv
// Scoreboard bench for hex2decdigi_seq: four parameterisations share one
// clock/reset; expected results carry the cycle on which done must appear.
module tb_hex2decdigi_seq;

  typedef struct {
    int          due;
    logic        ovf;
    logic [11:0] bcd;
    logic [20:0] digi;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hex;
  logic [3:0]  vld;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          done_cnt [4];
  item_t       sbq [4][$];

  logic        busy0, done0, ovf0;  logic [11:0] bcd0;  logic [20:0] digi0;
  logic        busy1, done1, ovf1;  logic [11:0] bcd1;  logic [20:0] digi1;
  logic        busy2, done2, ovf2;  logic [7:0]  bcd2;  logic [13:0] digi2;
  logic        busy3, done3, ovf3;  logic [7:0]  bcd3;  logic [13:0] digi3;

  hex2decdigi_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) u0 (
    .clock(clk), .rst(rst), .hex_valid(vld[0]), .hex(hex),
    .busy(busy0), .done(done0), .overflow(ovf0), .bcd(bcd0), .digi(digi0));
  hex2decdigi_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) u1 (
    .clock(clk), .rst(rst), .hex_valid(vld[1]), .hex(hex),
    .busy(busy1), .done(done1), .overflow(ovf1), .bcd(bcd1), .digi(digi1));
  hex2decdigi_seq #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(0)) u2 (
    .clock(clk), .rst(rst), .hex_valid(vld[2]), .hex(hex),
    .busy(busy2), .done(done2), .overflow(ovf2), .bcd(bcd2), .digi(digi2));
  hex2decdigi_seq #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(0)) u3 (
    .clock(clk), .rst(rst), .hex_valid(vld[3]), .hex(hex[5:0]),
    .busy(busy3), .done(done3), .overflow(ovf3), .bcd(bcd3), .digi(digi3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void push(input int id, input int due, input logic o,
                               input logic [11:0] b, input logic [20:0] g);
    item_t it;
    it.due  = due;
    it.ovf  = o;
    it.bcd  = b;
    it.digi = g;
    sbq[id].push_back(it);
  endfunction

  function automatic void chk(input int id, input logic d, input logic o,
                              input logic [11:0] b, input logic [20:0] g);
    item_t it;
    if (d === 1'b1) begin
      done_cnt[id]++;
      total++;
      if (sbq[id].size() == 0) begin
        bad++;
        $display("FAIL unexpected_done u%0d: got bcd=%0h digi=%0h at cycle %0d, want no result",
                 id, b, g, cyc);
      end else begin
        it = sbq[id].pop_front();
        if (cyc != it.due || o !== it.ovf || b !== it.bcd || g !== it.digi) begin
          bad++;
          $display("FAIL result u%0d: got cyc=%0d ovf=%0b bcd=%0h digi=%0h want cyc=%0d ovf=%0b bcd=%0h digi=%0h",
                   id, cyc, o, b, g, it.due, it.ovf, it.bcd, it.digi);
        end
      end
    end else if (sbq[id].size() > 0 && cyc > sbq[id][0].due) begin
      it = sbq[id].pop_front();
      total++;
      bad++;
      $display("FAIL timeout u%0d: got no done by cycle %0d, want done at %0d (bcd=%0h)",
               id, cyc, it.due, it.bcd);
    end
  endfunction

  always @(negedge clk) begin
    chk(0, done0, ovf0, bcd0, digi0);
    chk(1, done1, ovf1, bcd1, digi1);
    chk(2, done2, ovf2, 12'(bcd2), 21'(digi2));
    chk(3, done3, ovf3, 12'(bcd3), 21'(digi3));
  end

  task automatic pulse(input logic [3:0] m, input logic [7:0] v);
    hex = v;
    vld = m;
    @(negedge clk);
    vld = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_ovf"},  32'(ovf0),  32'd0);
    check({tag, "_bcd"},  32'(bcd0),  32'd0);
    check({tag, "_digi"}, 32'(digi0), 32'({7'h3F, 7'h3F, 7'h3F}));
  endtask

  int n0;
  int dc;

  initial begin
    rst = 1'b1;
    hex = '0;
    vld = '0;
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    idle(3);
    check_reset0("rst");
    check("rst_digi_blank", 32'(digi1), 32'({7'h00, 7'h00, 7'h3F}));
    check("rst_digi_d2",    32'(digi2), 32'({7'h3F, 7'h3F}));
    check("rst_digi_w6",    32'(digi3), 32'({7'h3F, 7'h3F}));
    rst = 1'b0;
    idle(1);

    // single conversion, full-scale value
    push(0, cyc + 10, 1'b0, 12'h255, {7'h5B, 7'h6D, 7'h6D});
    pulse(4'b0001, 8'd255);
    check("busy_conv", 32'(busy0), 32'd1);
    idle(9);
    check("busy_after_done", 32'(busy0), 32'd0);
    idle(2);

    // blanking on and off, zero input
    push(0, cyc + 10, 1'b0, 12'h007, {7'h3F, 7'h3F, 7'h07});
    push(1, cyc + 10, 1'b0, 12'h007, {7'h00, 7'h00, 7'h07});
    pulse(4'b0011, 8'd7);
    idle(10);
    push(1, cyc + 10, 1'b0, 12'h000, {7'h00, 7'h00, 7'h3F});
    pulse(4'b0010, 8'd0);
    idle(10);
    push(1, cyc + 10, 1'b0, 12'h105, {7'h06, 7'h3F, 7'h6D});
    pulse(4'b0010, 8'd105);
    idle(10);

    // narrow width and two-digit overflow
    push(3, cyc + 8, 1'b0, 12'h059, {7'h6D, 7'h6F});
    pulse(4'b1000, 8'd59);
    idle(8);
    push(2, cyc + 10, 1'b1, 12'h023, {7'h40, 7'h40});
    pulse(4'b0100, 8'd123);
    idle(10);
    push(2, cyc + 10, 1'b0, 12'h099, {7'h6F, 7'h6F});
    pulse(4'b0100, 8'd99);
    idle(10);

    // pending buffer: latest sample wins, middle one dropped
    n0 = cyc + 1;
    push(0, n0 + 9, 1'b0, 12'h010, {7'h3F, 7'h06, 7'h3F});
    pulse(4'b0001, 8'd10);
    idle(2);
    pulse(4'b0001, 8'd20);
    idle(1);
    push(0, n0 + 18, 1'b0, 12'h030, {7'h3F, 7'h4F, 7'h3F});
    pulse(4'b0001, 8'd30);
    for (int k = 0; k < 13; k++) begin
      check("busy_pending", 32'(busy0), 32'd1);
      @(negedge clk);
    end
    check("busy_after_pending", 32'(busy0), 32'd0);
    idle(2);

    // sample arriving exactly in the OUT cycle is loaded directly
    n0 = cyc + 1;
    push(0, n0 + 9, 1'b0, 12'h050, {7'h3F, 7'h6D, 7'h3F});
    pulse(4'b0001, 8'd50);
    idle(8);
    push(0, n0 + 18, 1'b0, 12'h044, {7'h3F, 7'h66, 7'h66});
    pulse(4'b0001, 8'd44);
    idle(9);
    check("busy_after_bypass", 32'(busy0), 32'd0);
    idle(2);

    // reset mid-conversion with pending full
    n0 = cyc + 1;
    pulse(4'b0001, 8'd10);
    pulse(4'b0001, 8'd20);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset0("midrst");
    dc = done_cnt[0];
    idle(25);
    check("no_done_after_rst", 32'(done_cnt[0]), 32'(dc));
    push(0, cyc + 10, 1'b0, 12'h099, {7'h3F, 7'h6F, 7'h6F});
    pulse(4'b0001, 8'd99);
    idle(12);

    for (int i = 0; i < 4; i++)
      check($sformatf("queue_empty_u%0d", i), 32'(sbq[i].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex2decdigi_seq.md
Name: hex2decdigi_seq

Overview:
Parametrised successor to the fixed 8-bit and 6-bit hex-to-digital-tube encoders. It converts a WIDTH-bit binary value to DIGITS BCD digits with a serial shift-add-3 (double-dabble) engine, one bit per clock. It then encodes each digit to 7-segment, with optional leading-zero blanking and overflow indication. A one-deep pending buffer keeps the latest sample that arrives while a conversion is running. It sits between datapath sources (filter output, timer hour/minute) and the display pins.

Parameters:
WIDTH, 8, binary input width (2..16)
DIGITS, 3, number of displayed decimal digits (1..5)
BLANK_LZ, 0, 1 = blank leading zeros (digit 0 never blanked)

Ports:
clock  input  1  system clock
rst  input  1  synchronous reset, active-high
hex_valid  input  1  new sample on hex this cycle
hex  input  WIDTH  unsigned binary value
busy  output  1  high in CONV or OUT, or while pending holds a sample
done  output  1  one-cycle pulse: new bcd/digi/overflow valid
overflow  output  1  last result >= 10^DIGITS
bcd  output  4*DIGITS  low DIGITS BCD digits of last result, digit 0 in LSBs
digi  output  7*DIGITS  segment codes, digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}, 1 = lit

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst is sampled on the rising edge of clock.
- Reset values: busy=0, done=0, overflow=0, bcd=0, pending empty, state IDLE. digi shows value 0: digit0=7'h3F; other digits 7'h3F if BLANK_LZ=0, 7'h00 if BLANK_LZ=1.
- Reset mid-operation aborts the conversion and drops pending; reset values appear after the reset edge.
- Segment map: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; blank=00; dash=40 (g only).
- FSM states:
  - IDLE: on hex_valid, load the value into the shift register, clear the internal BCD, set bit counter=WIDTH, go to CONV.
  - CONV: each cycle, add 3 to every internal BCD digit >=5, then shift {bcd,shift} left by 1 and decrement the counter. When the counter reaches 0, go to OUT.
  - OUT: register outputs and set done=1 for the next cycle. Next state, in priority order:
    - hex_valid this cycle: load hex, go to CONV.
    - pending full: load pending, clear it, go to CONV.
    - otherwise: go to IDLE.
- Latency: hex sampled at edge N; shifts on edges N+1..N+WIDTH; outputs and done update at edge N+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- Pending buffer:
  - hex_valid during CONV writes pending; a newer sample overwrites an older one (latest wins). Overwritten samples are silently dropped.
  - hex_valid during OUT bypasses pending and is loaded directly.
- Internal BCD has ceil(WIDTH/3)+1 digits, enough for the full input range.
- overflow=1 when any internal digit at index >= DIGITS is nonzero. When overflow=1:
  - every digi digit shows dash;
  - bcd still shows the low DIGITS digits.
- Blanking (BLANK_LZ=1, no overflow): digit i>0 is blank if it and all higher displayed digits are 0.
- done is high for exactly one cycle per completed conversion. digi/bcd/overflow hold their values until the next OUT.

Test Plan:
1. WIDTH=8, DIGITS=3, BLANK_LZ=0: hex_valid with 255 at edge N -> at edge N+9, bcd=12'h255, digi={5B,6D,6D} (digit2..0), overflow=0; done high 1 cycle; busy low after.
2. WIDTH=8, DIGITS=3: value 7 with BLANK_LZ=0 -> digi={3F,3F,07}; BLANK_LZ=1 -> {00,00,07}; value 0 with BLANK_LZ=1 -> {00,00,3F}.
3. WIDTH=6, DIGITS=2: 59 -> bcd=8'h59, digi={6D,6F}. WIDTH=8, DIGITS=2: 123 -> overflow=1, bcd=8'h23, digi={40,40}.
4. WIDTH=8: valid 10 at N, 20 at N+3, 30 at N+5 -> two done pulses, at N+9 (bcd=12'h010) and N+18 (bcd=12'h030). 20 is never output. busy stays high N..N+18.
5. WIDTH=8: hex_valid with 44 exactly in the OUT cycle of a prior conversion -> loaded directly, result bcd=12'h044 at 9 edges later; pending unaffected.
6. Assert rst at N+4 of a conversion with pending full -> next cycle, reset values; no done pulse follows; a new hex_valid afterwards converts normally.
